// File: rtl/uio_bank_ctrl.sv
// Runtime-configurable controller for the bidirectional uio pin bank.
// Each channel is configured over a serial chain: off, static, prescaled square wave or synchronised neighbour loopback.
module uio_bank_ctrl #(
    parameter int N_CH        = 8,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_data,
    input  logic            cfg_shift,
    input  logic            cfg_load,
    output logic            cfg_sdo,
    input  logic [N_CH-1:0] uio_in,
    output logic [N_CH-1:0] uio_out,
    output logic [N_CH-1:0] uio_oe,
    output logic            tick
);

    localparam int L = 4 * N_CH + DIV_W;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STATIC = 2'b01;
    localparam logic [1:0] MODE_SQUARE = 2'b10;
    localparam logic [1:0] MODE_LOOP   = 2'b11;

    logic [L-1:0]      sr_r;
    logic [L-1:0]      act_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [DIV_W-1:0]  reload_s;
    logic              cnt_zero_s;
    logic              tick_r;
    logic [N_CH-1:0]   t_r;
    logic [N_CH-1:0]   t_next_s;
    logic [N_CH-1:0]   nbr_s;
    logic [N_CH-1:0]   out_r;
    logic [N_CH-1:0]   oe_r;
    logic [N_CH-1:0]   out_next_s;
    logic [N_CH-1:0]   oe_next_s;
    logic [N_CH-1:0]   sync_r [SYNC_STAGES];

    // Next output values; square mode uses the post-tick phase so the pin edge lines up with tick.
    always_comb begin
        reload_s   = act_r[L-1 -: DIV_W];
        cnt_zero_s = (cnt_r == {DIV_W{1'b0}});
        t_next_s   = cnt_zero_s ? ~t_r : t_r;
        nbr_s      = {sync_r[SYNC_STAGES-1][0], sync_r[SYNC_STAGES-1][N_CH-1:1]};
        out_next_s = {N_CH{1'b0}};
        oe_next_s  = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            case (act_r[4*i +: 2])
                MODE_OFF: begin
                    out_next_s[i] = 1'b0;
                    oe_next_s[i]  = 1'b0;
                end
                MODE_STATIC: begin
                    out_next_s[i] = act_r[4*i+2] ^ act_r[4*i+3];
                    oe_next_s[i]  = 1'b1;
                end
                MODE_SQUARE: begin
                    out_next_s[i] = t_next_s[i] ^ act_r[4*i+3];
                    oe_next_s[i]  = 1'b1;
                end
                MODE_LOOP: begin
                    out_next_s[i] = nbr_s[i] ^ act_r[4*i+3];
                    oe_next_s[i]  = 1'b1;
                end
                default: begin
                    out_next_s[i] = 1'b0;
                    oe_next_s[i]  = 1'b0;
                end
            endcase
        end
    end

    // Configuration shift chain and active configuration; load captures the pre-shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r  <= {L{1'b0}};
            act_r <= {L{1'b0}};
        end else begin
            if (cfg_shift) begin
                sr_r <= {cfg_data, sr_r[L-1:1]};
            end
            if (cfg_load) begin
                act_r <= sr_r;
            end
        end
    end

    // Prescaler and square-wave phase; a load restarts both so loaded channels share phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
            t_r    <= {N_CH{1'b0}};
        end else if (cfg_load) begin
            cnt_r  <= sr_r[L-1 -: DIV_W];
            tick_r <= 1'b0;
            t_r    <= {N_CH{1'b0}};
        end else begin
            cnt_r  <= cnt_zero_s ? reload_s : (cnt_r - {{(DIV_W-1){1'b0}}, 1'b1});
            tick_r <= cnt_zero_s;
            t_r    <= t_next_s;
        end
    end

    // Loopback input synchronisers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {N_CH{1'b0}};
            end
        end else begin
            sync_r[0] <= uio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= {N_CH{1'b0}};
            oe_r  <= {N_CH{1'b0}};
        end else begin
            out_r <= out_next_s;
            oe_r  <= oe_next_s;
        end
    end

    assign cfg_sdo = sr_r[0];
    assign uio_out = out_r;
    assign uio_oe  = oe_r;
    assign tick    = tick_r;

endmodule

// File: tb/tb_uio_bank_ctrl.sv
// Directed scoreboard bench for uio_bank_ctrl (N_CH=8, DIV_W=8, SYNC_STAGES=2).
module tb_uio_bank_ctrl;

    localparam int L = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_data;
    logic       cfg_shift;
    logic       cfg_load;
    logic       cfg_sdo;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       tick;

    int n_assert = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    uio_bank_ctrl #(.N_CH(8), .DIV_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_shift (cfg_shift),
        .cfg_load  (cfg_load),
        .cfg_sdo   (cfg_sdo),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [63:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    function automatic logic [L-1:0] build_cfg(input logic [15:0] modes, input logic [7:0] vals,
                                               input logic [7:0] invs, input logic [7:0] div);
        logic [L-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[4*i +: 2] = modes[2*i +: 2];
            w[4*i+2]    = vals[i];
            w[4*i+3]    = invs[i];
        end
        w[L-1 -: 8] = div;
        return w;
    endfunction

    task automatic shift_word(input logic [L-1:0] w);
        for (int i = 0; i < L; i++) begin
            cfg_shift = 1'b1;
            cfg_data  = w[i];
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    logic [L-1:0] word_a;
    logic [15:0]  tv;
    logic [15:0]  ov;
    logic [15:0]  etv;
    logic [15:0]  eov;
    logic [L-1:0] sdo_v;
    logic         sdo_or;

    initial begin
        rst = 1'b1; cfg_data = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0; uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset pulsed mid-shift.
        cfg_shift = 1'b1; cfg_data = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_val("rst_out", 64'h0);  check(64'(uio_out));
        expect_val("rst_oe", 64'h0);   check(64'(uio_oe));
        expect_val("rst_tick", 64'h0); check(64'(tick));
        expect_val("rst_sdo", 64'h0);  check(64'(cfg_sdo));
        @(negedge clk);
        cfg_shift = 1'b0; cfg_data = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_val("rst_sr_zero", 64'h0);
        sdo_or = 1'b0;
        for (int i = 0; i < L; i++) begin
            sdo_or    = sdo_or | cfg_sdo;
            cfg_shift = 1'b1;
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        check(64'(sdo_or));
        expect_val("rst_act_oe", 64'h0);
        @(negedge clk);
        check(64'(uio_oe));

        // Static drive, inversion on upper half.
        shift_word(build_cfg(16'h5555, 8'hFF, 8'hF0, 8'h00));
        do_load();
        expect_val("static_oe_not_yet", 64'h00); check(64'(uio_oe));
        @(negedge clk);
        expect_val("static_oe", 64'hFF);  check(64'(uio_oe));
        expect_val("static_out", 64'h0F); check(64'(uio_out));

        // Square wave, div_reload=3 on channel 2.
        shift_word(build_cfg(16'h0020, 8'h00, 8'h00, 8'd3));
        do_load();
        etv = '0; eov = '0;
        for (int j = 1; j <= 16; j++) begin
            etv[j-1] = (j % 4 == 0);
            eov[j-1] = ((j / 4) % 2 == 1);
        end
        expect_val("sq3_tick", 64'(etv));
        expect_val("sq3_out2", 64'(eov));
        expect_val("sq3_oe", 64'h04);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            tv[j-1] = tick;
            ov[j-1] = uio_out[2];
        end
        check(64'(tv)); check(64'(ov)); check(64'(uio_oe));

        // Square wave, div_reload=0.
        shift_word(build_cfg(16'h0020, 8'h00, 8'h00, 8'd0));
        do_load();
        etv = '0; eov = '0;
        for (int j = 1; j <= 8; j++) begin
            etv[j-1] = 1'b1;
            eov[j-1] = (j % 2 == 1);
        end
        expect_val("sq0_tick", 64'(etv));
        expect_val("sq0_out2", 64'(eov));
        tv = '0; ov = '0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            tv[j-1] = tick;
            ov[j-1] = uio_out[2];
        end
        check(64'(tv)); check(64'(ov));

        // Loopback ch0 from uio_in[1], ch1 off.
        shift_word(build_cfg(16'h0003, 8'h00, 8'h00, 8'd0));
        do_load();
        @(negedge clk);
        expect_val("loop_oe", 64'h01); check(64'(uio_oe));
        expect_val("loop_rise", 64'hC);
        uio_in = 8'h02;
        tv = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            tv[j] = uio_out[0];
        end
        check(64'(tv[3:0]));

        // Loopback with inversion.
        shift_word(build_cfg(16'h0003, 8'h00, 8'h01, 8'd0));
        do_load();
        @(negedge clk);
        expect_val("loop_inv_idle", 64'h0); check(64'(uio_out[0]));
        expect_val("loop_inv_rise", 64'hC);
        uio_in = 8'h00;
        tv = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            tv[j] = uio_out[0];
        end
        check(64'(tv[3:0]));

        // Shift and load in the same cycle.
        word_a = build_cfg(16'h5555, 8'hA5, 8'h00, 8'h3C);
        shift_word(word_a);
        expect_val("sl_out", 64'hA5);
        expect_val("sl_oe", 64'hFF);
        expect_val("sl_sdo_stream", 64'({1'b1, word_a[L-1:1]}));
        cfg_shift = 1'b1; cfg_data = 1'b1; cfg_load = 1'b1;
        @(negedge clk);
        cfg_shift = 1'b0; cfg_data = 1'b0; cfg_load = 1'b0;
        @(negedge clk);
        check(64'(uio_out)); check(64'(uio_oe));
        for (int n = 0; n < L; n++) begin
            sdo_v[n]  = cfg_sdo;
            cfg_shift = 1'b1;
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        check(64'(sdo_v));

        // Square channel 3 turned off mid-period.
        shift_word(build_cfg(16'h0080, 8'h00, 8'h00, 8'd3));
        do_load();
        repeat (4) @(negedge clk);
        shift_word(build_cfg(16'h0000, 8'h00, 8'h00, 8'd3));
        expect_val("off_pre_out", 64'h08); check(64'(uio_out));
        do_load();
        expect_val("off_edge_oe", 64'h08); check(64'(uio_oe));
        @(negedge clk);
        expect_val("off_oe", 64'h00);  check(64'(uio_oe));
        expect_val("off_out", 64'h00); check(64'(uio_out));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uio_bank_ctrl.md
Name: uio_bank_ctrl

Overview:
- Parametrised, runtime-configurable controller for the bidirectional uio pin bank of a tile top.
- Replaces the fixed "all uio outputs and enables tied low" tie-off.
- Each channel is set independently to one of four modes through a serial configuration chain:
  - hi-Z / tied low
  - static drive
  - prescaled square wave
  - synchronised loopback of a neighbouring pin
- Sits between the tile-top ports and the core; configuration is driven from dedicated inputs.

Parameters:
- N_CH, 8, number of uio channels controlled (≥2).
- DIV_W, 8, prescaler reload width in bits.
- SYNC_STAGES, 2, synchroniser depth for loopback inputs (≥2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_data  input  1  serial configuration bit.
- cfg_shift  input  1  shift enable: one bit shifted per cycle while high.
- cfg_load  input  1  copy shift register into active configuration.
- cfg_sdo  output  1  shift register bit 0, used for daisy-chaining.
- uio_in  input  N_CH  pin input path.
- uio_out  output  N_CH  pin output path.
- uio_oe  output  N_CH  pin output enable (1 = drive).
- tick  output  1  one-cycle prescaler pulse.

Behaviour:
- Chain length L = 4*N_CH + DIV_W bits.
- Shift register SR[L-1:0]:
  - On cfg_shift: SR <= {cfg_data, SR[L-1:1]}.
  - After L shifts, the first bit shifted in sits at SR[0].
  - cfg_sdo = SR[0].
- Field map in SR:
  - Channel i mode = SR[4i+1:4i].
  - Channel i val = SR[4i+2].
  - Channel i inv = SR[4i+3].
  - div_reload = SR[L-1:L-DIV_W].
- cfg_load at edge k:
  - Active config ACT <= SR, using the pre-shift SR value if cfg_shift is high in the same cycle; SR still shifts.
  - Prescaler counter <= new div_reload.
  - All toggle flops cleared.
  - Outputs reflect the new config at edge k+1.
- Prescaler:
  - Down-counter CNT.
  - When CNT==0: tick=1 for that cycle and CNT <= div_reload; otherwise CNT <= CNT-1.
  - Period = div_reload+1 cycles; div_reload=0 gives tick every cycle.
  - tick is registered (asserted the cycle after CNT reaches 0).
- Per-channel modes (from ACT):
  - 00 off: uio_oe[i]=0, uio_out[i]=0; inv ignored.
  - 01 static: oe=1, out = val ^ inv.
  - 10 square: per-channel toggle flop T[i] flips on every tick; oe=1, out = T[i] ^ inv. Output period = 2*(div_reload+1) cycles.
  - 11 loopback: oe=1, out = S[(i+1) mod N_CH] ^ inv, where S[j] is uio_in[j] passed through SYNC_STAGES flops. Pin-to-pin latency = SYNC_STAGES+1 cycles.
- Output timing:
  - uio_out and uio_oe are registered, with no combinational path from any input.
  - val/inv/mode changes take effect 1 cycle after ACT updates.
- Reset (async assert, sync release by the integrator):
  - SR=0, ACT=0, CNT=0, T=0, synchronisers=0, tick=0.
  - uio_out=0, uio_oe=0, so every channel is off and the bank is electrically identical to the tie-off.
- Reset mid-shift or mid-load: all state cleared; a partial chain is discarded.
- Square-mode channels loaded together start in phase (T=0 after load).
- Mode 11 on a channel whose neighbour is also an output samples the driven pad value; this is legal and not special-cased.

Test Plan:
- Reset with rst pulsed during shifting → uio_out=0x00, uio_oe=0x00, tick=0, cfg_sdo=0; SR and ACT read 0 after release.
- Shift 40 bits (N_CH=8, DIV_W=8) configuring all channels mode 01, val=1, inv=0 on ch0–3 and inv=1 on ch4–7, then cfg_load → 1 cycle later uio_oe=0xFF, uio_out=0x0F.
- div_reload=3, ch2 mode 10 → tick every 4 cycles; uio_out[2] period 8 cycles, first rising edge on the first tick after load. With div_reload=0, tick stays high and the period is 2 cycles.
- ch0 mode 11, ch1 mode 00; drive uio_in[1] 0→1 → uio_out[0] rises exactly 3 cycles later (SYNC_STAGES=2). With inv=1, the output is complemented.
- cfg_shift and cfg_load asserted in the same cycle → ACT equals pre-shift SR, SR advances by one bit. Shifting 40 more bits shows cfg_sdo reproducing the loaded stream.
- Reconfigure a mode-10 channel to mode 00 mid-period → uio_oe and uio_out drop to 0 one cycle after the load edge.
